// File: rtl/ahb3lite_csr_bank.sv
// AHB3-Lite control/status register bank: CNT x 32-bit registers with run-time
// per-register access modes, byte/halfword writes, read wait states and ERROR responses.
module ahb3lite_csr_bank #(
  parameter int unsigned CNT     = 8,
  parameter int unsigned RD_WAIT = 0,
  parameter bit          ERR_EN  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [31:0]           HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  input  logic [CNT-1:0][2:0]   ACCESS,
  input  logic [CNT-1:0][31:0]  RSTVAL,
  input  logic [CNT-1:0][31:0]  REGIN,
  output logic [CNT-1:0][31:0]  REGOUT,
  output logic [CNT-1:0]        WSTB,
  output logic [CNT-1:0]        RSTB
);

  localparam int unsigned AW    = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [9:0]  CNT_W = 10'(CNT);

  typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_ERR1, S_ERR2} state_e;
  typedef enum logic [2:0] {M_RW, M_RO, M_WO, M_W1C, M_W1S, M_RC} mode_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 ph_valid_q, ph_write_q, ph_err_q;
  logic [AW-1:0]        ph_idx_q;
  logic [3:0]           ph_be_q;
  logic [CNT-1:0][31:0] regs_q, regs_d;
  logic [CNT-1:0]       wstb_q, wstb_d, rstb_q, rstb_d;

  logic                 acc, a_err;
  logic [3:0]           a_be;
  logic [31:0]          wmask, wbits, rdata;
  logic                 done_ok, wr_commit, rd_done;
  logic                 unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0], HADDR[31:12]};

  // Address phase decode; the range check covers the bank's 4 KB window so
  // accesses just past the last register are reported rather than aliased.
  assign acc = HSEL & HREADY & HTRANS[1];

  always_comb begin
    case (HSIZE)
      3'd0:    a_be = 4'h1 << HADDR[1:0];
      3'd1:    a_be = 4'h3 << HADDR[1:0];
      default: a_be = 4'hF;
    endcase
  end

  assign a_err = (HADDR[11:2] >= CNT_W) | (HSIZE > 3'd2)
               | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'd0))
               | ((HSIZE == 3'd1) & HADDR[0]);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ph_valid_q <= 1'b0;
      ph_write_q <= 1'b0;
      ph_err_q   <= 1'b0;
      ph_idx_q   <= '0;
      ph_be_q    <= '0;
    end else if (HREADY) begin
      ph_valid_q <= acc;
      ph_write_q <= HWRITE;
      ph_err_q   <= a_err;
      ph_idx_q   <= HADDR[AW+1:2];
      ph_be_q    <= a_be;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE and ERR2 are both completing cycles, so either may accept the next phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      S_RWAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q > 3'd1) cnt_d = cnt_q - 3'd1;
        else              state_d = S_IDLE;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      default: begin
        HRESP   = (state_q == S_ERR2);
        state_d = S_IDLE;
        if (acc) begin
          if (a_err) begin
            if (ERR_EN) state_d = S_ERR1;
          end else if (!HWRITE && (RD_WAIT > 0)) begin
            state_d = S_RWAIT;
            cnt_d   = 3'(RD_WAIT);
          end
        end
      end
    endcase
  end

  assign done_ok   = ph_valid_q & ~ph_err_q & (state_q == S_IDLE);
  assign wr_commit = done_ok & ph_write_q;
  assign rd_done   = done_ok & ~ph_write_q;

  assign wmask = {{8{ph_be_q[3]}}, {8{ph_be_q[2]}}, {8{ph_be_q[1]}}, {8{ph_be_q[0]}}};
  assign wbits = HWDATA & wmask;

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < CNT; i++) begin
      if (ph_idx_q == AW'(i)) begin
        case (ACCESS[i])
          M_RW, M_W1C, M_W1S, M_RC: rdata = regs_q[i];
          M_WO:                     rdata = '0;
          default:                  rdata = REGIN[i];
        endcase
      end
    end
  end

  assign HRDATA = rd_done ? rdata : '0;

  // Software write first, then the hardware term; set/clear priority lives in
  // the ordering of the two terms per mode.
  always_comb begin
    regs_d = regs_q;
    wstb_d = '0;
    rstb_d = '0;
    for (int unsigned i = 0; i < CNT; i++) begin
      wstb_d[i] = wr_commit && (ph_idx_q == AW'(i));
      rstb_d[i] = rd_done && (ph_idx_q == AW'(i));
      case (ACCESS[i])
        M_RW, M_WO: if (wstb_d[i]) regs_d[i] = wbits | (regs_q[i] & ~wmask);
        M_W1C:      regs_d[i] = (regs_q[i] & ~(wstb_d[i] ? wbits : '0)) | REGIN[i];
        M_W1S:      regs_d[i] = (regs_q[i] | (wstb_d[i] ? wbits : '0))
                              & ~(REGIN[i] & ~(wstb_d[i] ? wbits : '0));
        M_RC:       regs_d[i] = (rstb_d[i] ? '0 : regs_q[i]) | REGIN[i];
        default:    regs_d[i] = REGIN[i];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      regs_q <= RSTVAL;
      wstb_q <= '0;
      rstb_q <= '0;
    end else begin
      regs_q <= regs_d;
      wstb_q <= wstb_d;
      rstb_q <= rstb_d;
    end
  end

  assign REGOUT = regs_q;
  assign WSTB   = wstb_q;
  assign RSTB   = rstb_q;

endmodule

// File: tb/tb_ahb3lite_csr_bank.sv
// Self-checking bench for ahb3lite_csr_bank (CNT=8, RD_WAIT=2, ERR_EN=1):
// directed scenarios plus random traffic against a byte-lane reference model.
module tb_ahb3lite_csr_bank;
  localparam int unsigned CNT = 8;
  localparam int          RDW = 2;

  logic                 CLK = 1'b0;
  logic                 RESETn;
  logic                 HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [31:0]          HADDR, HWDATA, HRDATA;
  logic [2:0]           HSIZE, HBURST;
  logic [3:0]           HPROT;
  logic [1:0]           HTRANS;
  logic [CNT-1:0][2:0]  ACCESS;
  logic [CNT-1:0][31:0] RSTVAL, REGIN, REGOUT;
  logic [CNT-1:0]       WSTB, RSTB;

  assign HREADY = HREADYOUT;
  always #5 CLK = ~CLK;

  ahb3lite_csr_bank #(.CNT(CNT), .RD_WAIT(RDW), .ERR_EN(1'b1)) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .ACCESS(ACCESS), .RSTVAL(RSTVAL), .REGIN(REGIN), .REGOUT(REGOUT),
    .WSTB(WSTB), .RSTB(RSTB)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0]  cfg_mode  [CNT];
  logic [31:0] cfg_rst   [CNT];
  logic [31:0] cfg_regin [CNT];
  logic [31:0] mdl       [CNT];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic bit is_ro(input logic [2:0] m);
    return (m == 3'd1) || (m >= 3'd6);
  endfunction

  // Hardware-side effect of REGIN on register idx; wr1 = bits software wrote as 1.
  task automatic hw_update(input int idx, input logic [31:0] wr1);
    logic [2:0] m;
    m = cfg_mode[idx];
    if (m == 3'd3 || m == 3'd5) mdl[idx] = mdl[idx] | cfg_regin[idx];
    else if (m == 3'd4)         mdl[idx] = mdl[idx] & ~(cfg_regin[idx] & ~wr1);
    else if (is_ro(m))          mdl[idx] = cfg_regin[idx];
  endtask

  task automatic bus_idle;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2;
    HBURST = 3'd0; HPROT = 4'h3; HWDATA = '0;
  endtask

  task automatic apply_cfg_reset;
    for (int i = 0; i < CNT; i++) begin
      ACCESS[i] = cfg_mode[i];
      RSTVAL[i] = cfg_rst[i];
      REGIN[i]  = cfg_regin[i];
    end
    bus_idle();
    RESETn = 1'b0;
    tick();
    tick();
    RESETn = 1'b1;
    tick();
    for (int i = 0; i < CNT; i++) begin
      mdl[i] = cfg_rst[i];
      hw_update(i, '0);
    end
  endtask

  task automatic cfg_all(input logic [2:0] m);
    for (int i = 0; i < CNT; i++) begin
      cfg_mode[i] = m; cfg_rst[i] = '0; cfg_regin[i] = '0;
    end
  endtask

  // Single transfer; returns at the sample point of the cycle after completion.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rd, output bit werr,
                      output bit ferr, output int waits, output bit dirty, output bit tmo);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    HWDATA = wr ? wd : $urandom;
    waits = 0; werr = 1'b0; dirty = 1'b0; tmo = 1'b0;
    while (HREADYOUT !== 1'b1 && waits < 20) begin
      werr  = werr | (HRESP === 1'b1);
      dirty = dirty | (HRDATA !== 32'h0);
      waits++;
      tick();
    end
    tmo  = (waits >= 20);
    rd   = HRDATA;
    ferr = (HRESP === 1'b1);
    tick();
  endtask

  task automatic model_access(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wd, output logic [31:0] erd, output bit eerr,
                              output int ewaits, output logic [CNT-1:0] ewstb,
                              output logic [CNT-1:0] erstb);
    int w, off, nb;
    logic [31:0] lanes;
    logic [2:0]  m;
    w = int'(addr >> 2); off = int'(addr & 32'h3); nb = 1 << size;
    eerr = (w >= CNT) || (size > 3'd2) || (size == 3'd2 && off != 0)
        || (size == 3'd1 && (off % 2) == 1);
    erd = '0; ewstb = '0; erstb = '0; ewaits = eerr ? 1 : 0;
    if (!eerr) begin
      m = cfg_mode[w];
      if (wr) begin
        lanes = '0;
        for (int b = 0; b < 4; b++)
          if (b >= off && b < off + nb) lanes[8*b +: 8] = 8'hFF;
        if (m == 3'd0 || m == 3'd2) mdl[w] = (wd & lanes) | (mdl[w] & ~lanes);
        else if (m == 3'd3)         mdl[w] = mdl[w] & ~(wd & lanes);
        else if (m == 3'd4)         mdl[w] = mdl[w] | (wd & lanes);
        hw_update(w, (m == 3'd4) ? (wd & lanes) : 32'h0);
        ewstb[w] = 1'b1;
      end else begin
        ewaits = RDW;
        erd = is_ro(m) ? cfg_regin[w] : (m == 3'd2) ? 32'h0 : mdl[w];
        if (m == 3'd5) mdl[w] = '0;
        hw_update(w, '0);
        erstb[w] = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    cfg_all(3'd0);
    for (int i = 0; i < CNT; i++) cfg_rst[i] = $urandom;
    cfg_rst[0] = 32'hA5A5_0001;
    for (int i = 0; i < CNT; i++) begin
      ACCESS[i] = cfg_mode[i]; RSTVAL[i] = cfg_rst[i]; REGIN[i] = '0;
    end
    bus_idle();
    RESETn = 1'b0;
    tick(); tick();
    checks++;
    if (REGOUT[0] !== 32'hA5A5_0001) begin
      errors++; $display("FAIL reset_regout0: got %h want %h", REGOUT[0], 32'hA5A5_0001);
    end
    checks++;
    if ({HREADYOUT, HRESP} !== 2'b10 || HRDATA !== 32'h0) begin
      errors++; $display("FAIL reset_bus: hreadyout=%b hresp=%b hrdata=%h want 1 0 0", HREADYOUT, HRESP, HRDATA);
    end
    checks++;
    if (WSTB !== '0 || RSTB !== '0) begin
      errors++; $display("FAIL reset_strobes: wstb=%h rstb=%h want 0 0", WSTB, RSTB);
    end
    for (int i = 1; i < CNT; i++) begin
      checks++;
      if (REGOUT[i] !== cfg_rst[i]) begin
        errors++; $display("FAIL reset_regout%0d: got %h want %h", i, REGOUT[i], cfg_rst[i]);
      end
    end
    RESETn = 1'b1;
    tick();
  endtask

  task automatic test_rw_byte;
    logic [31:0] rd; bit werr, ferr, dirty, tmo; int waits;
    cfg_all(3'd0);
    apply_cfg_reset();
    xfer(1'b1, 32'h08, 3'd2, 32'h1111_1111, rd, werr, ferr, waits, dirty, tmo);
    xfer(1'b1, 32'h09, 3'd0, 32'h0000_3C00, rd, werr, ferr, waits, dirty, tmo);
    checks++;
    if (REGOUT[2] !== 32'h1111_3C11 || waits != 0 || ferr) begin
      errors++; $display("FAIL rw_byte_write: regout=%h waits=%0d resp=%b want 11113c11 0 0", REGOUT[2], waits, ferr);
    end
    checks++;
    if (WSTB !== 8'h04) begin
      errors++; $display("FAIL rw_byte_wstb: got %h want 04", WSTB);
    end
    tick();
    checks++;
    if (WSTB !== 8'h00) begin
      errors++; $display("FAIL rw_byte_wstb_once: got %h want 00", WSTB);
    end
    xfer(1'b0, 32'h08, 3'd2, 32'h0, rd, werr, ferr, waits, dirty, tmo);
    checks++;
    if (rd !== 32'h1111_3C11 || waits != RDW || ferr || werr || RSTB !== 8'h04) begin
      errors++; $display("FAIL rw_byte_read: data=%h waits=%0d resp=%b rstb=%h want 11113c11 %0d 0 04", rd, waits, ferr, RSTB, RDW);
    end
  endtask

  task automatic test_w1c_rc;
    logic [31:0] rd; bit werr, ferr, dirty, tmo; int waits;
    cfg_all(3'd0);
    cfg_mode[3] = 3'd3; cfg_rst[3] = 32'hFF;
    cfg_mode[4] = 3'd5; cfg_rst[4] = 32'h80;
    apply_cfg_reset();
    REGIN[3] = 32'h01;
    xfer(1'b1, 32'h0C, 3'd2, 32'h0F, rd, werr, ferr, waits, dirty, tmo);
    checks++;
    if (REGOUT[3] !== 32'hF1) begin
      errors++; $display("FAIL w1c_set_wins: got %h want f1", REGOUT[3]);
    end
    REGIN[3] = 32'h0;
    tick();
    checks++;
    if (REGOUT[3] !== 32'hF1) begin
      errors++; $display("FAIL w1c_hold: got %h want f1", REGOUT[3]);
    end
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, werr, ferr, waits, dirty, tmo);
    checks++;
    if (rd !== 32'h80 || REGOUT[4] !== 32'h0 || RSTB !== 8'h10) begin
      errors++; $display("FAIL rc_read: data=%h regout=%h rstb=%h want 80 0 10", rd, REGOUT[4], RSTB);
    end
  endtask

  task automatic test_rd_wait;
    logic [31:0] rd; bit werr, ferr, dirty, tmo; int waits;
    cfg_all(3'd0);
    cfg_mode[1] = 3'd1; cfg_regin[1] = 32'hCAFE;
    apply_cfg_reset();
    xfer(1'b0, 32'h04, 3'd2, 32'h0, rd, werr, ferr, waits, dirty, tmo);
    checks++;
    if (waits != RDW || tmo || werr || dirty) begin
      errors++; $display("FAIL rd_wait_timing: waits=%0d resp_in_wait=%b hrdata_in_wait=%b want %0d 0 0", waits, werr, dirty, RDW);
    end
    checks++;
    if (rd !== 32'hCAFE || ferr || RSTB !== 8'h02) begin
      errors++; $display("FAIL rd_wait_data: data=%h resp=%b rstb=%h want cafe 0 02", rd, ferr, RSTB);
    end
  endtask

  task automatic test_err;
    logic [31:0] rd; bit werr, ferr, dirty, tmo; int waits;
    logic [31:0] addrs [2];
    addrs[0] = 32'h20; addrs[1] = 32'h02;
    cfg_all(3'd0);
    cfg_rst[0] = 32'h600D_0000;
    apply_cfg_reset();
    for (int k = 0; k < 2; k++) begin
      xfer(1'b1, addrs[k], 3'd2, 32'hFFFF_FFFF, rd, werr, ferr, waits, dirty, tmo);
      checks++;
      if (waits != 1 || !werr || !ferr || rd !== 32'h0) begin
        errors++; $display("FAIL err_resp_%h: waits=%0d resp1=%b resp2=%b data=%h want 1 1 1 0", addrs[k], waits, werr, ferr, rd);
      end
      checks++;
      if (WSTB !== 8'h00 || REGOUT[0] !== 32'h600D_0000) begin
        errors++; $display("FAIL err_noeffect_%h: wstb=%h regout0=%h want 00 600d0000", addrs[k], WSTB, REGOUT[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int waits;
    cfg_all(3'd0);
    apply_cfg_reset();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = 3'd2;
    tick();
    HWDATA = 32'h5; HWRITE = 1'b0;
    checks++;
    if (HREADYOUT !== 1'b1) begin
      errors++; $display("FAIL b2b_write_zero_wait: hreadyout=%b want 1", HREADYOUT);
    end
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = '0;
    checks++;
    if (REGOUT[0] !== 32'h5 || WSTB !== 8'h01) begin
      errors++; $display("FAIL b2b_write: regout=%h wstb=%h want 5 01", REGOUT[0], WSTB);
    end
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 20) begin waits++; tick(); end
    checks++;
    if (waits != RDW || HRDATA !== 32'h5 || HRESP !== 1'b0) begin
      errors++; $display("FAIL b2b_read: waits=%0d data=%h resp=%b want %0d 5 0", waits, HRDATA, HRESP, RDW);
    end
    tick();
    checks++;
    if (RSTB !== 8'h01) begin
      errors++; $display("FAIL b2b_rstb: got %h want 01", RSTB);
    end
    HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0; HWRITE = 1'b1;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++; $display("FAIL busy_addr: hreadyout=%b hresp=%b want 1 0", HREADYOUT, HRESP);
    end
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
      errors++; $display("FAIL busy_data: hreadyout=%b hresp=%b hrdata=%h want 1 0 0", HREADYOUT, HRESP, HRDATA);
    end
    tick();
    checks++;
    if (WSTB !== 8'h00 || RSTB !== 8'h00 || REGOUT[0] !== 32'h5) begin
      errors++; $display("FAIL busy_noeffect: wstb=%h rstb=%h regout=%h want 00 00 5", WSTB, RSTB, REGOUT[0]);
    end
  endtask

  task automatic test_reset_abort;
    cfg_all(3'd0);
    cfg_rst[5] = 32'h1234;
    apply_cfg_reset();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h14; HWRITE = 1'b0; HSIZE = 3'd2;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    checks++;
    if (HREADYOUT !== 1'b0) begin
      errors++; $display("FAIL abort_in_wait: hreadyout=%b want 0", HREADYOUT);
    end
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
      errors++; $display("FAIL abort_bus: hreadyout=%b hresp=%b hrdata=%h want 1 0 0", HREADYOUT, HRESP, HRDATA);
    end
    tick();
    tick();
    checks++;
    if (RSTB !== 8'h00 || HREADYOUT !== 1'b1 || REGOUT[5] !== 32'h1234) begin
      errors++; $display("FAIL abort_nocommit: rstb=%h hreadyout=%b regout5=%h want 00 1 1234", RSTB, HREADYOUT, REGOUT[5]);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, addr, wd; bit werr, ferr, dirty, tmo, eerr, wr;
    int waits, ewaits; logic [2:0] size; logic [CNT-1:0] ewstb, erstb;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < CNT; i++) begin
        cfg_mode[i]  = 3'((i + 3 * r) % 8);
        cfg_rst[i]   = $urandom;
        cfg_regin[i] = is_ro(cfg_mode[i]) ? $urandom : 32'h0;
      end
      apply_cfg_reset();
      for (int t = 0; t < 40; t++) begin
        wr   = 1'($urandom_range(0, 1));
        addr = $urandom_range(0, 32'h27);
        size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        if (size <= 3'd2 && $urandom_range(0, 3) != 0) addr = addr & ~((32'h1 << size) - 32'h1);
        wd   = $urandom;
        model_access(wr, addr, size, wd, erd, eerr, ewaits, ewstb, erstb);
        xfer(wr, addr, size, wd, rd, werr, ferr, waits, dirty, tmo);
        checks++;
        if (tmo || waits != ewaits || ferr != eerr || werr != eerr || dirty) begin
          errors++; $display("FAIL rand_resp wr=%b a=%h sz=%0d: waits=%0d resp=%b/%b dirty=%b want waits=%0d resp=%b", wr, addr, size, waits, werr, ferr, dirty, ewaits, eerr);
        end
        checks++;
        if (rd !== erd) begin
          errors++; $display("FAIL rand_rdata wr=%b a=%h sz=%0d: got %h want %h", wr, addr, size, rd, erd);
        end
        checks++;
        if (WSTB !== ewstb || RSTB !== erstb) begin
          errors++; $display("FAIL rand_strobes a=%h: wstb=%h rstb=%h want %h %h", addr, WSTB, RSTB, ewstb, erstb);
        end
        for (int i = 0; i < CNT; i++) begin
          checks++;
          if (REGOUT[i] !== mdl[i]) begin
            errors++; $display("FAIL rand_regout%0d after a=%h wr=%b: got %h want %h", i, addr, wr, REGOUT[i], mdl[i]);
          end
        end
      end
    end
  endtask

  initial begin
    RESETn = 1'b0;
    bus_idle();
    ACCESS = '0; RSTVAL = '0; REGIN = '0;
    test_reset();
    test_rw_byte();
    test_w1c_rc();
    test_rd_wait();
    test_err();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb3lite_csr_bank.md
# ahb3lite_csr_bank

Parametrised AHB3-Lite control/status register bank with CNT 32-bit registers. Each register has a run-time access mode: RW, RO, WO, W1C, W1S or read-to-clear. The bank supports byte and halfword writes, configurable read wait states, ERROR responses for out-of-range or misaligned accesses, and per-register read/write strobes. It sits behind the AHB3-Lite decoder/mux and serves as the register file of every peripheral core in the library.

## Interface
- CNT, 8: number of registers, 1..256; decoded index AW = max(1, clog2(CNT)) bits from HADDR[AW+1:2]
- RD_WAIT, 0: wait states inserted on every OKAY read, 0..7
- ERR_EN, 1: 1 = out-of-range/misaligned accesses get a two-cycle ERROR; 0 = ignored with OKAY (reads return 0)

Ports:
- CLK  in  1  clock
- RESETn  in  1  synchronous, active-low reset; clock CLK
- HSEL, HADDR[31:0], HWDATA[31:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HTRANS[1:0], HREADY  in  standard AHB3-Lite slave inputs; HBURST/HPROT ignored
- HRDATA  out  32  read data
- HREADYOUT  out  1  transfer done
- HRESP  out  1  0 OKAY, 1 ERROR
- ACCESS  in  [CNT][3]  per-register mode: 0 RW, 1 RO, 2 WO, 3 W1C, 4 W1S, 5 RC; 6/7 treated as RO
- RSTVAL  in  [CNT][32]  value loaded into REGOUT while RESETn low
- REGIN  in  [CNT][32]  hardware value: RO read source; set mask for W1C/RC; clear mask for W1S
- REGOUT  out  [CNT][32]  software-visible register state
- WSTB  out  [CNT]  1-cycle pulse after a committed write
- RSTB  out  [CNT]  1-cycle pulse after a completed OKAY read

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Capture index, HWRITE, byte enables and error flag. BUSY/IDLE or unselected transfers get a zero-wait OKAY and have no side effects.
- Byte enables, little-endian:
  - word: 4'hF
  - halfword: 4'h3 << HADDR[1:0]
  - byte: 4'h1 << HADDR[1:0]
- Error flag set if any of:
  - index >= CNT
  - HSIZE > word
  - word access with HADDR[1:0] != 0
  - halfword access with HADDR[0] = 1
- Write commit at the data-phase completion edge, with merged value m = lanes-enabled HWDATA over old:
  - RW/WO: REGOUT <= m
  - RO: no change
  - W1C: clear enabled bits where HWDATA = 1
  - W1S: set enabled bits where HWDATA = 1
- Hardware update every cycle, applied after the write:
  - W1C/RC: REGOUT |= REGIN; set wins over a same-cycle clear
  - W1S: REGOUT &= ~REGIN, except bits being written 1 this cycle, where software set wins
  - RO: REGOUT <= REGIN
- Read data during the completing cycle:
  - RW/W1C/W1S/RC: REGOUT[idx]
  - RO: REGIN[idx] (live)
  - WO: 0
- RC: REGOUT[idx] cleared at the read completion edge; REGIN bits asserted in that cycle stay set.
- HRDATA = 0 in every cycle that is not an OKAY read completion.
- FSM states:
  - IDLE: no wait or error pending; zero-wait completions occur here
  - RWAIT: counter runs RD_WAIT..1 with HREADYOUT = 0, returns to IDLE with HREADYOUT = 1
  - ERR1: HREADYOUT = 0, HRESP = 1
  - ERR2: HREADYOUT = 1, HRESP = 1, then IDLE
- Transition triggers:
  - accepted read with RD_WAIT > 0 → RWAIT
  - accepted erroring access with ERR_EN = 1 → ERR1
- Erroring accesses never modify REGOUT and never pulse strobes. With ERR_EN = 0 they complete zero-wait OKAY with no effect.
- A new address phase is accepted only in the completing (HREADY = 1) cycle of the previous data phase.

## Timing
- Writes: zero wait states. REGOUT updated at the data-phase edge; WSTB[idx] high the cycle after that edge.
- Reads: data phase lasts 1 + RD_WAIT cycles; RSTB[idx] high the cycle after completion.
- Back-to-back write then read of the same register returns the newly written value.
- ERROR response is always exactly 2 cycles.
- Reset values:
  - REGOUT = RSTVAL
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0
  - WSTB = 0, RSTB = 0
  - FSM = IDLE, pending phase dropped
- Reset asserted mid-wait or mid-error aborts the transfer; no commit.

## Test plan
- Reset with RSTVAL[0] = 32'hA5A5_0001 → REGOUT[0] = 32'hA5A5_0001, HREADYOUT = 1, HRESP = 0.
- RW reg 2: byte write 8'h3C to 0x09 over 32'h1111_1111 → REGOUT[2] = 32'h1111_3C11; WSTB[2] pulses once; read returns 32'h1111_3C11.
- W1C reg 3 = 32'hFF: write 32'h0F while REGIN[3] = 32'h01 in the same cycle → 32'hF1. RC reg 4 = 32'h80: read returns 32'h80, then REGOUT[4] = 0.
- RD_WAIT = 2: read of RO reg 1 with REGIN[1] = 32'hCAFE → HREADYOUT low 2 cycles, then 32'hCAFE with HRESP = 0; RSTB[1] pulses.
- CNT = 8, write to 0x20 and word write to 0x02 → each gets ERR1/ERR2 (HREADYOUT 0 then 1, HRESP 1 both cycles); REGOUT unchanged; no WSTB.
- Pipelined write reg 0 = 32'h5 immediately followed by read reg 0 → read returns 32'h5; HTRANS = BUSY in between → no strobe, OKAY.
